// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry type codes and helpers for the reorder buffer.
package reorder_buffer_pkg;

  localparam int TagBus  = 5;
  localparam int DataBus = 32;
  localparam int RegBus  = 5;

  typedef enum logic [1:0] {
    REG    = 2'd0,
    BRANCH = 2'd1,
    STORE  = 2'd2,
    JUMP   = 2'd3
  } rob_type_e;

  localparam logic               Valid   = 1'b1;
  localparam logic               Invalid = 1'b0;
  localparam logic [DataBus-1:0] Null    = '0;

  function automatic logic writes_reg(input rob_type_e t);
    return (t == REG) || (t == JUMP);
  endfunction

  function automatic logic is_control(input rob_type_e t);
    return (t == BRANCH) || (t == JUMP);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of allocation, CDB, operand-query and commit signals around the ROB.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int TAG_W = TagBus
) ();

  logic               ID_alloc_valid;
  rob_type_e          ID_type;
  logic [RegBus-1:0]  ID_reg_dest;
  logic [TAG_W-1:0]   ROB_free_tag;
  logic               ROB_full;

  logic               ALU_cdb_valid;
  logic [TAG_W-1:0]   ALU_cdb_tag;
  logic [DataBus-1:0] ALU_cdb_data;
  logic               ALU_cdb_mispredict;
  logic [DataBus-1:0] ALU_cdb_target;

  logic               LSB_cdb_valid;
  logic [TAG_W-1:0]   LSB_cdb_tag;
  logic [DataBus-1:0] LSB_cdb_data;

  logic [TAG_W-1:0]   query1_tag;
  logic [TAG_W-1:0]   query2_tag;
  logic               query1_ready;
  logic [DataBus-1:0] query1_data;
  logic               query2_ready;
  logic [DataBus-1:0] query2_data;

  logic               ROB_data_valid;
  logic [RegBus-1:0]  ROB_reg_dest;
  logic [TAG_W-1:0]   ROB_tag;
  logic [DataBus-1:0] ROB_data;
  logic               ROB_store_commit;
  logic [TAG_W-1:0]   ROB_store_tag;
  logic               clear;
  logic [DataBus-1:0] clear_pc;

  modport master (
    output ID_alloc_valid, ID_type, ID_reg_dest,
    output ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data, ALU_cdb_mispredict, ALU_cdb_target,
    output LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data,
    output query1_tag, query2_tag,
    input  ROB_free_tag, ROB_full,
    input  query1_ready, query1_data, query2_ready, query2_data,
    input  ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data,
    input  ROB_store_commit, ROB_store_tag, clear, clear_pc
  );

  modport slave (
    input  ID_alloc_valid, ID_type, ID_reg_dest,
    input  ALU_cdb_valid, ALU_cdb_tag, ALU_cdb_data, ALU_cdb_mispredict, ALU_cdb_target,
    input  LSB_cdb_valid, LSB_cdb_tag, LSB_cdb_data,
    input  query1_tag, query2_tag,
    output ROB_free_tag, ROB_full,
    output query1_ready, query1_data, query2_ready, query2_data,
    output ROB_data_valid, ROB_reg_dest, ROB_tag, ROB_data,
    output ROB_store_commit, ROB_store_tag, clear, clear_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit queue: allocates from ID, collects CDB results, retires the
// head entry each cycle and flushes everything on a mispredicted control op.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TAG_W = TagBus
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  reorder_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] MaxTag = TAG_W'(DEPTH);

  logic               busy_reg       [DEPTH];
  logic               ready_reg      [DEPTH];
  logic               mispredict_reg [DEPTH];
  rob_type_e          type_reg       [DEPTH];
  logic [RegBus-1:0]  dest_reg       [DEPTH];
  logic [DataBus-1:0] data_reg       [DEPTH];
  logic [DataBus-1:0] target_reg     [DEPTH];

  logic [IDX_W-1:0]   head_reg;
  logic [IDX_W-1:0]   tail_reg;
  logic [IDX_W:0]     count_reg;

  logic               data_valid_reg;
  logic [RegBus-1:0]  reg_dest_reg;
  logic [TAG_W-1:0]   commit_tag_reg;
  logic [DataBus-1:0] commit_data_reg;
  logic               store_commit_reg;
  logic [TAG_W-1:0]   store_tag_reg;
  logic               clear_reg;
  logic [DataBus-1:0] clear_pc_reg;

  logic               full;
  logic               alloc_fire;
  logic               commit_fire;
  logic               flush;
  rob_type_e          head_type;
  logic [TAG_W-1:0]   head_tag;
  logic [DEPTH-1:0]   alu_hit;
  logic [DEPTH-1:0]   lsb_hit;

  assign full        = (count_reg == (IDX_W+1)'(DEPTH));
  assign head_type   = type_reg[head_reg];
  assign head_tag    = TAG_W'(head_reg) + TAG_W'(1);
  assign commit_fire = busy_reg[head_reg] && ready_reg[head_reg];
  assign flush       = commit_fire && is_control(head_type) && mispredict_reg[head_reg];
  // full comes from the registered count, so a same-cycle commit never frees a slot early
  assign alloc_fire  = bus.ID_alloc_valid && !full && !clear_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [TAG_W-1:0] EntryTag = TAG_W'(gi + 1);
      localparam logic [IDX_W-1:0] EntryIdx = IDX_W'(gi);

      assign alu_hit[gi] = bus.ALU_cdb_valid && (bus.ALU_cdb_tag == EntryTag)
                           && busy_reg[gi] && !clear_reg;
      assign lsb_hit[gi] = bus.LSB_cdb_valid && (bus.LSB_cdb_tag == EntryTag)
                           && busy_reg[gi] && !clear_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          busy_reg[gi]       <= 1'b0;
          ready_reg[gi]      <= 1'b0;
          mispredict_reg[gi] <= 1'b0;
          type_reg[gi]       <= REG;
          dest_reg[gi]       <= '0;
          data_reg[gi]       <= '0;
          target_reg[gi]     <= '0;
        end else if (rdy) begin
          if (flush) begin
            busy_reg[gi]  <= 1'b0;
            ready_reg[gi] <= 1'b0;
          end else begin
            if (commit_fire && head_reg == EntryIdx) begin
              busy_reg[gi]  <= 1'b0;
              ready_reg[gi] <= 1'b0;
            end
            if (alloc_fire && tail_reg == EntryIdx) begin
              busy_reg[gi]       <= 1'b1;
              ready_reg[gi]      <= 1'b0;
              mispredict_reg[gi] <= 1'b0;
              type_reg[gi]       <= bus.ID_type;
              dest_reg[gi]       <= bus.ID_reg_dest;
            end
            if (alu_hit[gi]) begin
              ready_reg[gi]      <= 1'b1;
              data_reg[gi]       <= bus.ALU_cdb_data;
              mispredict_reg[gi] <= bus.ALU_cdb_mispredict;
              target_reg[gi]     <= bus.ALU_cdb_target;
            end else if (lsb_hit[gi]) begin
              ready_reg[gi] <= 1'b1;
              data_reg[gi]  <= bus.LSB_cdb_data;
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      count_reg        <= '0;
      data_valid_reg   <= 1'b0;
      reg_dest_reg     <= '0;
      commit_tag_reg   <= '0;
      commit_data_reg  <= '0;
      store_commit_reg <= 1'b0;
      store_tag_reg    <= '0;
      clear_reg        <= 1'b0;
      clear_pc_reg     <= '0;
    end else if (!rdy) begin
      // Drop pending pulses so a stall never replays a commit afterwards.
      data_valid_reg   <= 1'b0;
      store_commit_reg <= 1'b0;
      clear_reg        <= 1'b0;
    end else begin
      data_valid_reg   <= commit_fire && writes_reg(head_type);
      store_commit_reg <= commit_fire && (head_type == STORE);
      clear_reg        <= flush;
      if (commit_fire && writes_reg(head_type)) begin
        reg_dest_reg    <= dest_reg[head_reg];
        commit_tag_reg  <= head_tag;
        commit_data_reg <= data_reg[head_reg];
      end
      if (commit_fire && head_type == STORE) begin
        store_tag_reg <= head_tag;
      end
      if (flush) begin
        clear_pc_reg <= target_reg[head_reg];
        head_reg     <= '0;
        tail_reg     <= '0;
        count_reg    <= '0;
      end else begin
        if (commit_fire) head_reg <= head_reg + IDX_W'(1);
        if (alloc_fire)  tail_reg <= tail_reg + IDX_W'(1);
        count_reg <= count_reg + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit_fire);
      end
    end
  end

  // Operand lookup: a completed entry wins, else forward the live CDB (ALU first).
  logic [TAG_W-1:0]   q_tag   [2];
  logic               q_ready [2];
  logic [DataBus-1:0] q_data  [2];

  assign q_tag[0] = bus.query1_tag;
  assign q_tag[1] = bus.query2_tag;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_query
      logic [IDX_W-1:0] q_idx;
      assign q_idx = IDX_W'(q_tag[gi] - TAG_W'(1));

      always_comb begin
        q_ready[gi] = Invalid;
        q_data[gi]  = Null;
        if (q_tag[gi] != '0) begin
          if (q_tag[gi] <= MaxTag && busy_reg[q_idx] && ready_reg[q_idx]) begin
            q_ready[gi] = Valid;
            q_data[gi]  = data_reg[q_idx];
          end else if (bus.ALU_cdb_valid && bus.ALU_cdb_tag == q_tag[gi]) begin
            q_ready[gi] = Valid;
            q_data[gi]  = bus.ALU_cdb_data;
          end else if (bus.LSB_cdb_valid && bus.LSB_cdb_tag == q_tag[gi]) begin
            q_ready[gi] = Valid;
            q_data[gi]  = bus.LSB_cdb_data;
          end
        end
      end
    end
  endgenerate

  assign bus.query1_ready     = q_ready[0];
  assign bus.query1_data      = q_data[0];
  assign bus.query2_ready     = q_ready[1];
  assign bus.query2_data      = q_data[1];

  assign bus.ROB_free_tag     = TAG_W'(tail_reg) + TAG_W'(1);
  assign bus.ROB_full         = full;
  assign bus.ROB_data_valid   = data_valid_reg & rdy;
  assign bus.ROB_reg_dest     = reg_dest_reg;
  assign bus.ROB_tag          = commit_tag_reg;
  assign bus.ROB_data         = commit_data_reg;
  assign bus.ROB_store_commit = store_commit_reg & rdy;
  assign bus.ROB_store_tag    = store_tag_reg;
  assign bus.clear            = clear_reg & rdy;
  assign bus.clear_pc         = clear_pc_reg;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: query vector table plus hand-timed
// sequences for commit order, wrap, flush, stores and stalls.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(5)) bus ();

  reorder_buffer #(.DEPTH(16), .TAG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        alu_v;
    logic [4:0]  alu_t;
    logic [31:0] alu_d;
    logic        lsb_v;
    logic [4:0]  lsb_t;
    logic [31:0] lsb_d;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        r1;
    logic [31:0] d1;
    logic        r2;
    logic [31:0] d2;
  } qvec_t;

  qvec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ID_alloc_valid     = 1'b0;
    bus.ID_type            = REG;
    bus.ID_reg_dest        = 5'd0;
    bus.ALU_cdb_valid      = 1'b0;
    bus.ALU_cdb_tag        = 5'd0;
    bus.ALU_cdb_data       = 32'd0;
    bus.ALU_cdb_mispredict = 1'b0;
    bus.ALU_cdb_target     = 32'd0;
    bus.LSB_cdb_valid      = 1'b0;
    bus.LSB_cdb_tag        = 5'd0;
    bus.LSB_cdb_data       = 32'd0;
    bus.query1_tag         = 5'd0;
    bus.query2_tag         = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rdy = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic alloc(input rob_type_e t, input logic [4:0] d);
    bus.ID_alloc_valid = 1'b1;
    bus.ID_type        = t;
    bus.ID_reg_dest    = d;
    step();
    bus.ID_alloc_valid = 1'b0;
  endtask

  task automatic alu(input logic v, input logic [4:0] t, input logic [31:0] d,
                     input logic mis, input logic [31:0] tgt);
    bus.ALU_cdb_valid      = v;
    bus.ALU_cdb_tag        = t;
    bus.ALU_cdb_data       = d;
    bus.ALU_cdb_mispredict = mis;
    bus.ALU_cdb_target     = tgt;
  endtask

  task automatic lsb(input logic v, input logic [4:0] t, input logic [31:0] d);
    bus.LSB_cdb_valid = v;
    bus.LSB_cdb_tag   = t;
    bus.LSB_cdb_data  = d;
  endtask

  task automatic check_commit(input string name, input logic v, input logic [4:0] dest,
                              input logic [4:0] tag, input logic [31:0] data);
    $display("%s: valid=%0d dest=%0d tag=%0d data=0x%0h", name, bus.ROB_data_valid,
             bus.ROB_reg_dest, bus.ROB_tag, bus.ROB_data);
    check({name, ".valid"}, 32'(bus.ROB_data_valid), 32'(v));
    if (v) begin
      check({name, ".dest"}, 32'(bus.ROB_reg_dest), 32'(dest));
      check({name, ".tag"},  32'(bus.ROB_tag),      32'(tag));
      check({name, ".data"}, bus.ROB_data,          data);
    end
  endtask

  logic [31:0] order_data [3];

  initial begin
    vecs[0] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd2,  5'd1, 1'b1, 32'h2222, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd3, 32'hAB,   1'b0, 5'd0, 32'h0,    5'd3,  5'd0, 1'b1, 32'hAB,   1'b0, 32'h0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd4, 32'h55,   5'd4,  5'd3, 1'b1, 32'h55,   1'b0, 32'h0};
    vecs[3] = '{1'b1, 5'd4, 32'h66,   1'b1, 5'd3, 32'h77,   5'd4,  5'd3, 1'b1, 32'h66,   1'b1, 32'h77};
    vecs[4] = '{1'b1, 5'd2, 32'h9999, 1'b0, 5'd0, 32'h0,    5'd2,  5'd5, 1'b1, 32'h2222, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd1, 32'h1111, 5'd0,  5'd1, 1'b0, 32'h0,    1'b1, 32'h1111};
    vecs[6] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    5'd18, 5'd4, 1'b0, 32'h0,    1'b0, 32'h0};
    vecs[7] = '{1'b1, 5'd3, 32'h66,   1'b1, 5'd3, 32'h77,   5'd3,  5'd4, 1'b1, 32'h66,   1'b0, 32'h0};

    // Reset state
    do_reset();
    check("reset.free_tag",     32'(bus.ROB_free_tag),     1);
    check("reset.full",         32'(bus.ROB_full),         0);
    check("reset.data_valid",   32'(bus.ROB_data_valid),   0);
    check("reset.store_commit", 32'(bus.ROB_store_commit), 0);
    check("reset.clear",        32'(bus.clear),            0);
    check("reset.clear_pc",     bus.clear_pc,              0);
    check("reset.rob_data",     bus.ROB_data,              0);

    // Single REG commit: CDB at t, commit visible at t+2
    alloc(REG, 5'd5);
    check("t1.free_tag", 32'(bus.ROB_free_tag), 2);
    alu(1'b1, 5'd1, 32'h1234, 1'b0, 32'h0);
    step();
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check_commit("t1.t+1", 1'b0, 5'd0, 5'd0, 32'h0);
    step();
    check_commit("t1.t+2", 1'b1, 5'd5, 5'd1, 32'h1234);
    step();
    check_commit("t1.after", 1'b0, 5'd0, 5'd0, 32'h0);

    // Out-of-order completion retires in program order
    do_reset();
    alloc(REG, 5'd1);
    alloc(REG, 5'd2);
    alloc(REG, 5'd3);
    alu(1'b1, 5'd3, 32'h33, 1'b0, 32'h0);
    step();
    alu(1'b1, 5'd2, 32'h22, 1'b0, 32'h0);
    step();
    alu(1'b1, 5'd1, 32'h11, 1'b0, 32'h0);
    step();
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check_commit("order.pre", 1'b0, 5'd0, 5'd0, 32'h0);
    order_data[0] = 32'h11;
    order_data[1] = 32'h22;
    order_data[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      step();
      check_commit($sformatf("order.c%0d", i), 1'b1, 5'(i + 1), 5'(i + 1), order_data[i]);
    end
    step();
    check_commit("order.post", 1'b0, 5'd0, 5'd0, 32'h0);

    // Fill, overflow, commit-frees-next-cycle and tag wrap
    do_reset();
    for (int i = 0; i < 16; i++) alloc(REG, 5'(i + 1));
    check("full.full",     32'(bus.ROB_full),     1);
    check("full.free_tag", 32'(bus.ROB_free_tag), 1);
    alloc(REG, 5'd31);
    check("full.ovf_full",     32'(bus.ROB_full),     1);
    check("full.ovf_free_tag", 32'(bus.ROB_free_tag), 1);
    alu(1'b1, 5'd1, 32'hA1, 1'b0, 32'h0);
    step();
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("full.pre_commit_full", 32'(bus.ROB_full), 1);
    bus.ID_alloc_valid = 1'b1;
    bus.ID_type        = REG;
    bus.ID_reg_dest    = 5'd30;
    step();
    bus.ID_alloc_valid = 1'b0;
    check_commit("full.commit", 1'b1, 5'd1, 5'd1, 32'hA1);
    check("full.freed",        32'(bus.ROB_full),     0);
    check("full.same_cyc_tag", 32'(bus.ROB_free_tag), 1);
    alloc(REG, 5'd9);
    check("full.wrap_free_tag", 32'(bus.ROB_free_tag), 2);
    check("full.refull",        32'(bus.ROB_full),     1);
    check_commit("full.no_commit", 1'b0, 5'd0, 5'd0, 32'h0);

    // Mispredicted BRANCH flushes younger entries (reset discards the full queue)
    do_reset();
    check("br.reset_full",     32'(bus.ROB_full),     0);
    check("br.reset_free_tag", 32'(bus.ROB_free_tag), 1);
    alloc(REG, 5'd1);
    alloc(BRANCH, 5'd0);
    alloc(REG, 5'd3);
    alloc(REG, 5'd4);
    alu(1'b1, 5'd1, 32'h11, 1'b0, 32'h0);
    step();
    alu(1'b1, 5'd2, 32'h0, 1'b1, 32'h100);
    step();
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check_commit("br.reg", 1'b1, 5'd1, 5'd1, 32'h11);
    check("br.clear_early", 32'(bus.clear), 0);
    step();
    $display("br.flush: clear=%0d clear_pc=0x%0h free_tag=%0d", bus.clear, bus.clear_pc,
             bus.ROB_free_tag);
    check("br.clear",      32'(bus.clear),        1);
    check("br.clear_pc",   bus.clear_pc,          32'h100);
    check("br.free_tag",   32'(bus.ROB_free_tag), 1);
    check("br.full",       32'(bus.ROB_full),     0);
    check("br.no_reg",     32'(bus.ROB_data_valid), 0);
    bus.ID_alloc_valid = 1'b1;
    bus.ID_type        = REG;
    bus.ID_reg_dest    = 5'd6;
    alu(1'b1, 5'd3, 32'h33, 1'b0, 32'h0);
    step();
    bus.ID_alloc_valid = 1'b0;
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    check("br.clear_pulse",      32'(bus.clear),        0);
    check("br.alloc_ignored",    32'(bus.ROB_free_tag), 1);
    step();
    check_commit("br.quiet1", 1'b0, 5'd0, 5'd0, 32'h0);
    step();
    check_commit("br.quiet2", 1'b0, 5'd0, 5'd0, 32'h0);

    // Mispredicted JUMP commits its register and flushes in the same cycle
    do_reset();
    alloc(JUMP, 5'd7);
    alu(1'b1, 5'd1, 32'h44, 1'b1, 32'h200);
    step();
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    check_commit("jmp.commit", 1'b1, 5'd7, 5'd1, 32'h44);
    check("jmp.clear",    32'(bus.clear), 1);
    check("jmp.clear_pc", bus.clear_pc,   32'h200);
    step();
    check("jmp.clear_end", 32'(bus.clear),        0);
    check("jmp.free_tag",  32'(bus.ROB_free_tag), 1);

    // STORE release, with both CDB ports writing in the same cycle
    do_reset();
    alloc(STORE, 5'd0);
    alloc(REG, 5'd8);
    lsb(1'b1, 5'd1, 32'h0);
    alu(1'b1, 5'd2, 32'h88, 1'b0, 32'h0);
    step();
    lsb(1'b0, 5'd0, 32'h0);
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    $display("st.commit: store_commit=%0d store_tag=%0d", bus.ROB_store_commit, bus.ROB_store_tag);
    check("st.store_commit", 32'(bus.ROB_store_commit), 1);
    check("st.store_tag",    32'(bus.ROB_store_tag),    1);
    check("st.no_reg",       32'(bus.ROB_data_valid),   0);
    step();
    check_commit("st.reg", 1'b1, 5'd8, 5'd2, 32'h88);
    check("st.store_end", 32'(bus.ROB_store_commit), 0);

    // rdy low freezes state and blanks pulses
    do_reset();
    alloc(REG, 5'd3);
    rdy = 1'b0;
    alu(1'b1, 5'd1, 32'h77, 1'b0, 32'h0);
    bus.ID_alloc_valid = 1'b1;
    step();
    bus.ID_alloc_valid = 1'b0;
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    rdy = 1'b1;
    check("stall.free_tag", 32'(bus.ROB_free_tag), 2);
    step();
    check_commit("stall.cdb_ignored", 1'b0, 5'd0, 5'd0, 32'h0);
    alu(1'b1, 5'd1, 32'h77, 1'b0, 32'h0);
    step();
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    step();
    check_commit("stall.commit", 1'b1, 5'd3, 5'd1, 32'h77);
    rdy = 1'b0;
    #1;
    check("stall.gated", 32'(bus.ROB_data_valid), 0);
    rdy = 1'b1;
    step();
    check("stall.no_replay", 32'(bus.ROB_data_valid), 0);

    // Operand query table: tags 1..4 allocated, only tag 2 complete
    do_reset();
    for (int i = 0; i < 4; i++) alloc(REG, 5'(i + 1));
    alu(1'b1, 5'd2, 32'h2222, 1'b0, 32'h0);
    step();
    alu(1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      alu(vecs[i].alu_v, vecs[i].alu_t, vecs[i].alu_d, 1'b0, 32'h0);
      lsb(vecs[i].lsb_v, vecs[i].lsb_t, vecs[i].lsb_d);
      bus.query1_tag = vecs[i].q1;
      bus.query2_tag = vecs[i].q2;
      #1;
      $display("query vec %0d: q1=%0d -> %0d/0x%0h  q2=%0d -> %0d/0x%0h", i, vecs[i].q1,
               bus.query1_ready, bus.query1_data, vecs[i].q2, bus.query2_ready, bus.query2_data);
      check($sformatf("query%0d.r1", i), 32'(bus.query1_ready), 32'(vecs[i].r1));
      check($sformatf("query%0d.d1", i), bus.query1_data,       vecs[i].d1);
      check($sformatf("query%0d.r2", i), 32'(bus.query2_ready), 32'(vecs[i].r2));
      check($sformatf("query%0d.d2", i), bus.query2_data,       vecs[i].d2);
      idle_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
